// File: rtl/fifo_rd_drain.sv
// Read-domain drain engine for an async FIFO: issues reads only when space is
// guaranteed, buffers the one-cycle read latency in two entries, frames bursts.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_read_error,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_sticky,
  output logic                  busy
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic                  infl_q, infl_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  err_q, err_d;

  logic                  hs;
  logic [1:0]            pending;
  logic [1:0]            occ_pop;

  // Stream handshake: m_valid/m_data/m_last hold until m_valid & m_ready on a rising edge.
  assign m_valid    = (occ_q != 2'd0);
  assign hs         = m_valid & m_ready;
  assign m_data     = buf0_q;
  assign m_last     = m_valid & (beat_q == LAST_BEAT);
  assign rd_count   = rd_count_q;
  assign err_sticky = err_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    beat_d     = beat_q;
    rd_count_d = rd_count_q;

    // Words already committed to the buffer: stored plus the one arriving now.
    pending   = occ_q + {1'b0, infl_q};
    fifo_r_en = (state_q == RUN) & en & ~fifo_empty &
                ((pending <= 2'd1) | ((pending == 2'd2) & hs));

    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = STOP;
      STOP: begin
        if (en) state_d = RUN;
        else if ((occ_q == 2'd0) && !infl_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entry 0 is always the head; a pop shifts entry 1 forward before the tail write.
    occ_pop = occ_q - {1'b0, hs};
    if (hs) buf0_d = buf1_q;
    if (infl_q) begin
      if (occ_pop == 2'd0) buf0_d = fifo_rdata;
      else                 buf1_d = fifo_rdata;
    end
    occ_d  = occ_pop + {1'b0, infl_q};
    infl_d = fifo_r_en;

    if (hs) begin
      beat_d     = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      rd_count_d = rd_count_q + CNT_WIDTH'(1);
    end

    err_d = err_q | fifo_read_error;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      infl_q     <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      beat_q     <= '0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      infl_q     <= infl_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      beat_q     <= beat_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain: behavioural FIFO source, handshake logger,
// and a linear sequence of checked scenarios.
module tb_fifo_rd_drain;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        en;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        fifo_read_error;
  logic        fifo_r_en;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] rd_count;
  logic        err_sticky;
  logic        busy;

  int n_asserts = 0;
  int n_fail    = 0;

  fifo_rd_drain #(.DATA_WIDTH(8), .BURST_LEN(4), .CNT_WIDTH(16)) dut (
    .rclk            (rclk),
    .rrst            (rrst),
    .en              (en),
    .fifo_empty      (fifo_empty),
    .fifo_rdata      (fifo_rdata),
    .fifo_read_error (fifo_read_error),
    .fifo_r_en       (fifo_r_en),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .rd_count        (rd_count),
    .err_sticky      (err_sticky),
    .busy            (busy)
  );

  // clock
  always #5 rclk = ~rclk;

  // FIFO source model: one-cycle read latency, pointer survives rrst.
  logic [7:0] fifo_mem [0:255];
  int wr_idx = 0;
  int rd_idx = 0;
  int r_en_cnt = 0;
  int underflow_cnt = 0;
  logic [7:0] exp_q [$];

  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_en_cnt <= 0;
    end else if (fifo_r_en) begin
      r_en_cnt <= r_en_cnt + 1;
      if (rd_idx == wr_idx) begin
        underflow_cnt <= underflow_cnt + 1;
      end else begin
        fifo_rdata <= fifo_mem[rd_idx];
        rd_idx     <= rd_idx + 1;
      end
    end
  end

  // handshake logger
  logic [7:0] obs_data [0:63];
  logic       obs_last [0:63];
  int hs_cnt = 0;

  always @(negedge rclk) begin
    if (rrst) begin
      hs_cnt = 0;
    end else if (m_valid && m_ready && hs_cnt < 64) begin
      obs_data[hs_cnt] = m_data;
      obs_last[hs_cnt] = m_last;
      hs_cnt = hs_cnt + 1;
    end
  end

  // driver / checker tasks
  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic mid();
    @(negedge rclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo_mem[wr_idx] = w;
    exp_q.push_back(w);
    wr_idx++;
  endtask

  task automatic do_reset();
    en = 1'b0;
    m_ready = 1'b0;
    fifo_read_error = 1'b0;
    rrst = 1'b1;
    cyc();
    cyc();
    rrst = 1'b0;
  endtask

  task automatic chk_stream(input string tag, input int base, input int n);
    chk({tag, "_hs_count"}, hs_cnt, n);
    for (int i = 0; i < n; i++) chk({tag, "_data"}, obs_data[i], exp_q[base + i]);
  endtask

  int base;

  initial begin
    rrst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    fifo_read_error = 1'b0;

    // reset values
    mid();
    chk("rst_r_en", fifo_r_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_busy", busy, 0);
    cyc();
    rrst = 1'b0;

    // basic drain with cycle-exact latency
    do_reset();
    base = exp_q.size();
    push(8'h11); push(8'h22); push(8'h33);
    cyc(); en = 1'b1; m_ready = 1'b1; mid();
    chk("basic_idle_r_en", fifo_r_en, 0);
    chk("basic_idle_busy", busy, 0);
    cyc(); mid();
    chk("basic_t0_r_en", fifo_r_en, 1);
    chk("basic_t0_valid", m_valid, 0);
    cyc(); mid();
    chk("basic_t1_r_en", fifo_r_en, 1);
    chk("basic_t1_valid", m_valid, 0);
    cyc(); mid();
    chk("basic_t2_r_en", fifo_r_en, 1);
    chk("basic_t2_valid", m_valid, 1);
    chk("basic_t2_data", m_data, 8'h11);
    cyc(); mid();
    chk("basic_t3_r_en", fifo_r_en, 0);
    chk("basic_t3_data", m_data, 8'h22);
    cyc(); mid();
    chk("basic_t4_data", m_data, 8'h33);
    chk("basic_t4_valid", m_valid, 1);
    cyc(); mid();
    chk("basic_t5_valid", m_valid, 0);
    chk("basic_rd_count", rd_count, 3);
    chk("basic_r_en_cnt", r_en_cnt, 3);
    chk("basic_busy_run", busy, 1);
    chk_stream("basic", base, 3);
    for (int i = 0; i < 3; i++) chk("basic_no_last", obs_last[i], 0);
    cyc(); en = 1'b0;
    repeat (3) cyc();
    mid();
    chk("basic_busy_off", busy, 0);

    // backpressure: only two reads outstanding, head held stable
    do_reset();
    base = exp_q.size();
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    cyc(); en = 1'b1;
    repeat (8) cyc();
    mid();
    chk("bp_r_en_cnt", r_en_cnt, 2);
    chk("bp_r_en_low", fifo_r_en, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_head", m_data, 8'hA0);
    repeat (3) cyc();
    mid();
    chk("bp_head_stable", m_data, 8'hA0);
    chk("bp_last_stable", m_last, 0);
    cyc(); m_ready = 1'b1;
    repeat (6) cyc();
    mid();
    chk("bp_rd_count", rd_count, 6);
    chk("bp_drained", m_valid, 0);
    chk_stream("bp", base, 6);
    cyc(); en = 1'b0;
    repeat (3) cyc();

    // burst framing with alternating ready
    do_reset();
    base = exp_q.size();
    for (int i = 0; i < 9; i++) push(8'hD0 + 8'(i));
    cyc(); en = 1'b1; m_ready = 1'b1;
    repeat (30) begin
      cyc();
      m_ready = ~m_ready;
    end
    mid();
    chk("burst_rd_count", rd_count, 9);
    chk_stream("burst", base, 9);
    for (int i = 0; i < 9; i++) chk("burst_last", obs_last[i], (i == 3 || i == 7) ? 1 : 0);
    cyc(); en = 1'b0; m_ready = 1'b0;
    repeat (3) cyc();

    // stop mid-stream, then resume
    do_reset();
    base = exp_q.size();
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    m_ready = 1'b1;
    cyc(); en = 1'b1; mid();
    chk("stop_idle_r_en", fifo_r_en, 0);
    cyc(); mid();
    chk("stop_read_r_en", fifo_r_en, 1);
    cyc(); en = 1'b0; mid();
    chk("stop_fall_r_en", fifo_r_en, 0);
    chk("stop_fall_busy", busy, 1);
    cyc(); mid();
    chk("stop_deliver_valid", m_valid, 1);
    chk("stop_deliver_data", m_data, 8'hC0);
    chk("stop_deliver_r_en", fifo_r_en, 0);
    cyc(); mid();
    chk("stop_empty_valid", m_valid, 0);
    chk("stop_empty_busy", busy, 1);
    cyc(); mid();
    chk("stop_idle_busy", busy, 0);
    chk("stop_r_en_cnt", r_en_cnt, 1);
    chk("stop_rd_count", rd_count, 1);
    cyc(); en = 1'b1;
    repeat (10) cyc();
    mid();
    chk("resume_rd_count", rd_count, 5);
    chk("resume_r_en_cnt", r_en_cnt, 5);
    chk_stream("resume", base, 5);
    cyc(); en = 1'b0;
    repeat (3) cyc();

    // empty FIFO and sticky read error
    do_reset();
    cyc(); en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); mid();
      chk("empty_no_r_en", fifo_r_en, 0);
    end
    chk("empty_r_en_cnt", r_en_cnt, 0);
    cyc(); fifo_read_error = 1'b1; mid();
    chk("err_not_yet", err_sticky, 0);
    cyc(); fifo_read_error = 1'b0; mid();
    chk("err_set", err_sticky, 1);
    repeat (3) cyc();
    mid();
    chk("err_held", err_sticky, 1);

    // reset with two words buffered: B0 delivered, B1/B2 discarded, B3 next
    cyc(); m_ready = 1'b0;
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    repeat (5) cyc();
    m_ready = 1'b1;
    cyc(); m_ready = 1'b0;
    repeat (3) cyc();
    mid();
    chk("rstmid_pre_count", rd_count, 1);
    chk("rstmid_pre_head", m_data, 8'hB1);
    chk("rstmid_pre_valid", m_valid, 1);
    chk("rstmid_pre_err", err_sticky, 1);
    cyc();
    rrst = 1'b1;
    #1;
    chk("rstmid_valid", m_valid, 0);
    chk("rstmid_count", rd_count, 0);
    chk("rstmid_err", err_sticky, 0);
    chk("rstmid_r_en", fifo_r_en, 0);
    cyc(); cyc();
    rrst = 1'b0; en = 1'b1; m_ready = 1'b1;
    repeat (8) cyc();
    mid();
    chk("rstmid_hs_count", hs_cnt, 1);
    chk("rstmid_first_word", obs_data[0], 8'hB3);
    chk("rstmid_post_count", rd_count, 1);
    chk("rstmid_post_err", err_sticky, 0);

    chk("no_underflow", underflow_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain engine for the asynchronous FIFO, living entirely in the read clock domain. It issues `r_en` to the FIFO only when data is present and downstream space exists, absorbing the FIFO's one-cycle read latency in a 2-entry output buffer. It presents words on a valid/ready stream with burst framing and a delivered-word counter, and flags any FIFO read error it observes.

## Interface
- `DATA_WIDTH`, 8: FIFO word width.
- `BURST_LEN`, 4: beats per burst for `m_last` framing; ≥1.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

Ports:
- `rclk` in 1: read clock; all logic on rising edge.
- `rrst` in 1: asynchronous, active-high reset.
- `en` in 1: drain enable; sampled every cycle.
- `fifo_empty` in 1: FIFO `empty`.
- `fifo_rdata` in DATA_WIDTH: FIFO `data_out`, valid the cycle after an accepted `r_en`.
- `fifo_read_error` in 1: FIFO `read_error`.
- `fifo_r_en` out 1: FIFO `r_en`.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DATA_WIDTH: output word.
- `m_last` out 1: final beat of a burst.
- `rd_count` out CNT_WIDTH: words delivered (handshakes) since reset.
- `err_sticky` out 1: a FIFO read error was seen.
- `busy` out 1: state ≠ IDLE.

## Operation
- Terms:
  - handshake (hs) = `m_valid & m_ready`.
  - occ = buffered words, 0..2.
  - infl = a read issued last cycle, with data arriving this cycle, 0..1.
- States:
  - IDLE: `en` low, occ=0, infl=0. Goes to RUN when `en`=1.
  - RUN: reads permitted. Goes to STOP when `en`=0.
  - STOP: no new reads; in-flight and buffered words still delivered. Goes to RUN if `en`=1; goes to IDLE when occ=0, infl=0, `en`=0.
- `fifo_r_en` (combinational) = state==RUN & `en` & !`fifo_empty` & (occ+infl ≤ 1 | (occ+infl==2 & hs)).
  - Never asserted while `fifo_empty`=1.
  - Never over-commits the buffer.
- Capture: when infl=1, `fifo_rdata` is written to the buffer tail on that edge.
- Buffer order is strict FIFO; `m_data` is the head entry.
- `m_valid` = occ≠0.
- Capture and hs in the same cycle: occ is unchanged and the head advances.
- While `m_valid` & !`m_ready`, `m_data` and `m_last` stay stable.
- Beat counter 0..BURST_LEN-1:
  - Advances on hs and wraps to 0.
  - `m_last` = `m_valid` & beat==BURST_LEN-1.
  - Not reset by `en` changes; bursts may span STOP/RUN.
- `rd_count`: +1 per hs, wraps modulo 2^CNT_WIDTH.
- `err_sticky`: set on any cycle with `fifo_read_error`=1; cleared only by `rrst`.

## Timing
- Reset (async assert) values:
  - `fifo_r_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `rd_count`=0, `err_sticky`=0, `busy`=0.
  - State IDLE, occ=0, infl=0, beat=0.
- `rrst` mid-transfer: buffered and in-flight words are discarded. The FIFO's own read reset is expected to be asserted together.
- Latency with `en`=1 and an empty buffer:
  - Cycle T: `fifo_empty` falls, `fifo_r_en`=1.
  - Cycle T+1: data arrives and is captured.
  - Cycle T+2: `m_valid`=1.
- Throughput: 1 word/cycle sustained when `m_ready`=1 and the FIFO is non-empty.
- `m_ready`=0: at most 2 reads issue, then `fifo_r_en` stays 0 until hs.
- `en` falling in cycle T: no `fifo_r_en` from T onward. A read issued in T-1 is still captured and delivered.

## Test plan
- Basic drain:
  - FIFO preloaded with 0x11,0x22,0x33; `en`=1, `m_ready`=1.
  - `fifo_r_en` high 3 cycles; `m_data` 0x11,0x22,0x33 on consecutive cycles starting at T+2.
  - `rd_count`=3; `m_last` never asserts (BURST_LEN=4).
- Backpressure:
  - 6 words queued, `m_ready`=0.
  - Exactly 2 `fifo_r_en` pulses, `m_data`=word0 held stable.
  - After `m_ready`=1, all 6 words arrive in order with no gaps or duplicates.
- Burst framing:
  - 9 words with `m_ready` toggling 1,0,1,…
  - `m_last` on the 4th and 8th handshakes only; `rd_count`=9.
- Stop mid-stream:
  - `en` drops the cycle after a read issues.
  - That word is still delivered, no further `fifo_r_en`, `busy` falls once the buffer empties.
  - Re-raising `en` resumes with the next word.
- Error/empty:
  - `fifo_empty`=1 throughout, so `fifo_r_en` is never 1.
  - Forcing `fifo_read_error`=1 for one cycle sets `err_sticky`, which stays set until `rrst`.
- Reset mid-operation:
  - Assert `rrst` with occ=2.
  - Immediately `m_valid`=0, `rd_count`=0, `err_sticky`=0.
  - After release with `en`=1, the next FIFO word is the first output.
